// File: rtl/sram_arbiter.sv
// Two-master arbiter/sequencer in front of a registered-ready byte-lane SRAM.
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed priority (master 0).
module sram_arbiter #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              m0_valid_i,
   output logic              m0_ready_o,
   input  logic [3:0]        m0_wstrb_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [31:0]       m0_wdata_i,
   output logic [31:0]       m0_rdata_o,
   input  logic              m1_valid_i,
   output logic              m1_ready_o,
   input  logic [3:0]        m1_wstrb_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [31:0]       m1_wdata_i,
   output logic [31:0]       m1_rdata_o,
   output logic              s_select_o,
   input  logic              s_ready_i,
   output logic [3:0]        s_wstrb_o,
   output logic [ADDR_W-1:0] s_addr_o,
   output logic [31:0]       s_wdata_o,
   input  logic [31:0]       s_rdata_i,
   output logic              grant_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t state_q, state_d;
   logic   grant_q, grant_d;
   logic   winner;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
   logic last_q;

   // The pointer only matters on a tie; a lone requester always wins.
   always_comb begin
      if (m0_valid_i && m1_valid_i) begin
         winner = ~last_q;
      end else begin
         winner = ~m0_valid_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         last_q <= 1'b1;
      end else if (state_q == WAIT && s_ready_i) begin
         last_q <= grant_q;
      end
   end
`else
   always_comb begin
      winner = ~m0_valid_i;
   end
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         grant_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      s_select_o = 1'b0;
      s_wstrb_o  = 4'b0000;
      m0_ready_o = 1'b0;
      m1_ready_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (m0_valid_i || m1_valid_i) begin
               grant_d = winner;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            s_select_o = 1'b1;
            s_wstrb_o  = grant_q ? m1_wstrb_i : m0_wstrb_i;
            state_d    = WAIT;
         end
         WAIT: begin
            // Completion depends only on the SRAM and the registered grant,
            // never on the masters' valid inputs.
            if (s_ready_i) begin
               m0_ready_o = ~grant_q;
               m1_ready_o = grant_q;
               state_d    = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign s_addr_o   = grant_q ? m1_addr_i  : m0_addr_i;
   assign s_wdata_o  = grant_q ? m1_wdata_i : m0_wdata_i;
   assign m0_rdata_o = s_rdata_i;
   assign m1_rdata_o = s_rdata_i;
   assign grant_o    = grant_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: a behavioural SRAM, a reference memory/arbitration
// model feeding an expectation queue, and a negedge monitor that checks every output.
module tb_sram_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_valid_i, m0_ready_o, m1_valid_i, m1_ready_o;
   logic [3:0]  m0_wstrb_i, m1_wstrb_i, s_wstrb_o;
   logic [31:0] m0_addr_i, m1_addr_i, s_addr_o;
   logic [31:0] m0_wdata_i, m1_wdata_i, s_wdata_o;
   logic [31:0] m0_rdata_o, m1_rdata_o, s_rdata_i;
   logic        s_select_o, s_ready_i, grant_o;

   sram_arbiter #(.ADDR_W(32)) dut (
      .clk_i(clk), .rst_i(rst),
      .m0_valid_i(m0_valid_i), .m0_ready_o(m0_ready_o), .m0_wstrb_i(m0_wstrb_i),
      .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i), .m0_rdata_o(m0_rdata_o),
      .m1_valid_i(m1_valid_i), .m1_ready_o(m1_ready_o), .m1_wstrb_i(m1_wstrb_i),
      .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i), .m1_rdata_o(m1_rdata_o),
      .s_select_o(s_select_o), .s_ready_i(s_ready_i), .s_wstrb_o(s_wstrb_o),
      .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_rdata_i(s_rdata_i),
      .grant_o(grant_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] init_val(input int i);
      return (i == 4) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(i));
   endfunction

   // Behavioural SRAM: ready and read data registered one cycle after select.
   logic [31:0] sram_mem [16];
   logic        sram_rdy, spur, mem_init;
   logic [31:0] sram_rd;
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 16; i++) sram_mem[i] <= init_val(i);
         sram_rdy <= 1'b0;
         sram_rd  <= '0;
      end else begin
         sram_rdy <= s_select_o;
         if (s_select_o) begin
            sram_rd <= sram_mem[s_addr_o[5:2]];
            for (int b = 0; b < 4; b++)
               if (s_wstrb_o[b]) sram_mem[s_addr_o[5:2]][8*b +: 8] <= s_wdata_o[8*b +: 8];
         end
      end
   end
   assign s_ready_i = sram_rdy | spur;
   assign s_rdata_i = sram_rd;

   typedef struct {
      logic        m;
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } exp_t;

   exp_t        exp_q [$];
   logic [31:0] ref_mem [16];
   logic        last_served;
   int          tests = 0, fails = 0;
   int          last_sel = -1;
   bit          gap_chk = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: applies the transaction to ref_mem in service order.
   task automatic push_exp(input logic m, input logic [3:0] ws, input logic [31:0] a,
                           input logic [31:0] wd);
      exp_t e;
      int   idx;
      idx     = int'(a[5:2]);
      e.m     = m;
      e.addr  = a;
      e.wstrb = ws;
      e.wdata = wd;
      e.rdata = ref_mem[idx];
      for (int b = 0; b < 4; b++)
         if (ws[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
      last_served = m;
      exp_q.push_back(e);
   endtask

   function automatic logic model_winner();
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      return ~last_served;
`else
      return 1'b0;
`endif
   endfunction

   task automatic drive(input logic m, input logic v, input logic [3:0] ws,
                        input logic [31:0] a, input logic [31:0] wd);
      if (m) begin
         m1_valid_i = v; m1_wstrb_i = ws; m1_addr_i = a; m1_wdata_i = wd;
      end else begin
         m0_valid_i = v; m0_wstrb_i = ws; m0_addr_i = a; m0_wdata_i = wd;
      end
   endtask

   task automatic wait_ready(input logic m, input int start, output int lat);
      bit ok = 0;
      lat = -1;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (m ? m1_ready_o : m0_ready_o) begin
            ok  = 1;
            lat = cyc - start;
         end
      end
      if (!ok) begin
         tests++; fails++;
         $display("FAIL ready_timeout m%0d: got no ready, expected one within 20 cycles", m);
      end
   endtask

   task automatic wait_any();
      bit ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (m0_ready_o || m1_ready_o) ok = 1;
      end
      if (!ok) begin
         tests++; fails++;
         $display("FAIL tie_timeout: got no ready, expected one within 20 cycles");
      end
   endtask

   // Called just after a rising edge with the arbiter idle.
   task automatic single(input logic m, input logic [3:0] ws, input logic [31:0] a,
                         input logic [31:0] wd, input bit keep);
      int start, lat;
      push_exp(m, ws, a, wd);
      drive(m, 1'b1, ws, a, wd);
      start = cyc;
      wait_ready(m, start, lat);
      if (lat >= 0) check32("latency", 32'(lat), 32'd2);
      @(posedge clk); #1;
      if (!keep) drive(m, 1'b0, ws, a, wd);
   endtask

   // Monitor: select framing, address/strobe mux, ready pulses and read data.
   initial begin
      logic prev_sel = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_sel = 1'b0;
         end else begin
            if (s_select_o) begin
               check32("select_width", {31'b0, prev_sel}, 32'd0);
               if (exp_q.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL select_unexpected: got select, expected none pending");
               end else begin
                  e = exp_q[0];
                  check32("grant", {31'b0, grant_o}, {31'b0, e.m});
                  check32("s_addr", s_addr_o, e.addr);
                  check32("s_wstrb", {28'b0, s_wstrb_o}, {28'b0, e.wstrb});
                  if (e.wstrb != 4'b0000) check32("s_wdata", s_wdata_o, e.wdata);
               end
               if (gap_chk && last_sel >= 0) check32("select_gap", 32'(cyc - last_sel), 32'd3);
               last_sel = cyc;
            end else begin
               check32("wstrb_idle", {28'b0, s_wstrb_o}, 32'd0);
            end
            prev_sel = s_select_o;
            if (m0_ready_o && m1_ready_o) begin
               tests++; fails++;
               $display("FAIL both_ready: got both readies high, expected at most one");
            end else if (m0_ready_o || m1_ready_o) begin
               if (exp_q.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL ready_unexpected: got ready m%0d, expected none", m1_ready_o);
               end else begin
                  e = exp_q.pop_front();
                  check32("ready_master", {31'b0, m1_ready_o}, {31'b0, e.m});
                  if (e.wstrb == 4'b0000)
                     check32("rdata", m1_ready_o ? m1_rdata_o : m0_rdata_o, e.rdata);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a0, a1, a;
      logic        w, g0;
      int          start, lat;

      rst = 1'b1; mem_init = 1'b1; spur = 1'b0;
      drive(1'b0, 1'b0, 4'b0, '0, '0);
      drive(1'b1, 1'b0, 4'b0, '0, '0);
      for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
      last_served = 1'b1;
      repeat (2) @(posedge clk);
      #1 mem_init = 1'b0;
      check32("rst_select", {31'b0, s_select_o}, 32'd0);
      check32("rst_wstrb", {28'b0, s_wstrb_o}, 32'd0);
      check32("rst_m0_ready", {31'b0, m0_ready_o}, 32'd0);
      check32("rst_m1_ready", {31'b0, m1_ready_o}, 32'd0);
      check32("rst_grant", {31'b0, grant_o}, 32'd0);
      @(posedge clk); #1 rst = 1'b0;

      // Directed read, byte write and read-back of the written lane.
      single(1'b0, 4'b0000, 32'h0000_0010, 32'h0, 1'b0);
      single(1'b1, 4'b0100, 32'h0000_0008, 32'h00AB_0000, 1'b0);
      single(1'b0, 4'b0000, 32'h0000_0008, 32'h0, 1'b0);

      // Spurious SRAM ready while idle.
      g0 = grant_o;
      spur = 1'b1;
      @(negedge clk);
      check32("spur_m0_ready", {31'b0, m0_ready_o}, 32'd0);
      check32("spur_m1_ready", {31'b0, m1_ready_o}, 32'd0);
      @(posedge clk); #1 spur = 1'b0;
      check32("spur_select", {31'b0, s_select_o}, 32'd0);
      check32("spur_grant", {31'b0, grant_o}, {31'b0, g0});

      // Granted master withdraws valid during ISSUE; completion still expected.
      a = 32'($urandom_range(0, 15)) << 2;
      push_exp(1'b1, 4'b1111, a, 32'h5A5A_1234);
      drive(1'b1, 1'b1, 4'b1111, a, 32'h5A5A_1234);
      start = cyc;
      @(posedge clk); #1 m1_valid_i = 1'b0;
      wait_ready(1'b1, start, lat);
      if (lat >= 0) check32("drop_latency", 32'(lat), 32'd2);
      @(posedge clk); #1;

      // Randomized single-requester traffic.
      for (int i = 0; i < 30; i++) begin
         single(1'($urandom_range(0, 1)),
                ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000,
                32'($urandom_range(0, 15)) << 2, $urandom, 1'b0);
      end

      // Back-to-back from master 0.
      gap_chk = 1; last_sel = -1;
      for (int i = 0; i < 5; i++)
         single(1'b0, ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000,
                32'($urandom_range(0, 15)) << 2, $urandom, i < 4);
      gap_chk = 0;

      // Tie: both masters held valid for four transactions.
      gap_chk = 1; last_sel = -1;
      a0 = 32'($urandom_range(0, 15)) << 2;
      a1 = 32'($urandom_range(0, 15)) << 2;
      drive(1'b0, 1'b1, 4'b0, a0, '0);
      drive(1'b1, 1'b1, 4'b0, a1, '0);
      for (int k = 0; k < 4; k++) begin
         w = model_winner();
         push_exp(w, 4'b0000, w ? a1 : a0, 32'h0);
         wait_any();
         @(posedge clk); #1;
         if (k == 3) begin
            m0_valid_i = 1'b0;
            m1_valid_i = 1'b0;
         end else if (w) begin
            a1 = 32'($urandom_range(0, 15)) << 2;
            m1_addr_i = a1;
         end else begin
            a0 = 32'($urandom_range(0, 15)) << 2;
            m0_addr_i = a0;
         end
      end
      gap_chk = 0;

      // Reset while master 1 is in WAIT; the held request is then served once.
      a = 32'($urandom_range(0, 15)) << 2;
      push_exp(1'b1, 4'b0000, a, 32'h0);
      drive(1'b1, 1'b1, 4'b0000, a, 32'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check32("arst_select", {31'b0, s_select_o}, 32'd0);
      check32("arst_wstrb", {28'b0, s_wstrb_o}, 32'd0);
      check32("arst_m0_ready", {31'b0, m0_ready_o}, 32'd0);
      check32("arst_m1_ready", {31'b0, m1_ready_o}, 32'd0);
      check32("arst_grant", {31'b0, grant_o}, 32'd0);
      void'(exp_q.pop_front());
      last_served = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      push_exp(1'b1, 4'b0000, a, 32'h0);
      rst = 1'b0;
      start = cyc;
      wait_ready(1'b1, start, lat);
      if (lat >= 0) check32("post_rst_latency", 32'(lat), 32'd2);
      @(posedge clk); #1 m1_valid_i = 1'b0;

      single(1'b0, 4'b0000, 32'h0000_0010, 32'h0, 1'b0);
      repeat (4) @(posedge clk);
      check32("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the byte-lane BSRAM block (native valid/ready memory interface).
- Typically master 0 is CPU instruction fetch and master 1 is the data/DMA port.
- Grants one master at a time, issues a single-cycle select pulse, waits for the SRAM's registered ready, then returns ready and read data to the granted master.
- Guarantees the SRAM never sees select or write strobes outside an issued transaction.

Parameters:
- ADDR_W, 32, width of address buses; passed through unmodified.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset
- m0_valid_i  in  1  master 0 request; held high until m0_ready_o
- m0_ready_o  out  1  master 0 transaction complete, one-cycle pulse
- m0_wstrb_i  in  4  master 0 byte write enables; 0 = read
- m0_addr_i  in  ADDR_W  master 0 byte address
- m0_wdata_i  in  32  master 0 write data
- m0_rdata_o  out  32  master 0 read data; valid when m0_ready_o
- m1_valid_i, m1_ready_o, m1_wstrb_i, m1_addr_i, m1_wdata_i, m1_rdata_o: as master 0
- s_select_o  out  1  SRAM select / clock enable
- s_ready_i  in  1  SRAM access complete; registered, one cycle after select
- s_wstrb_o  out  4  SRAM byte write enables
- s_addr_o  out  ADDR_W  SRAM address
- s_wdata_o  out  32  SRAM write data
- s_rdata_i  in  32  SRAM read data
- grant_o  out  1  currently granted master index, for debug and performance counters

Interface (already decided):
- One clock; reset is asynchronous and active-high.
- Clock is clk_i; reset is rst_i.

Behaviour:
- States: IDLE, ISSUE, WAIT. Reset state is IDLE.
- Reset values:
  - s_select_o=0, s_wstrb_o=0, m0_ready_o=0, m1_ready_o=0, grant_o=0.
  - Round-robin last-served pointer = 1, so master 0 wins the first tie.
- IDLE:
  - If any valid is high, register the winner into grant and go to ISSUE.
  - Otherwise stay in IDLE.
  - Grant changes only in IDLE.
- ISSUE (exactly one cycle):
  - s_select_o=1.
  - s_addr_o, s_wdata_o and s_wstrb_o are muxed combinationally from the granted master.
  - Next state is WAIT.
- WAIT:
  - s_select_o=0 and s_wstrb_o=0.
  - When s_ready_i=1: drive granted mN_ready_o=1 combinationally for that cycle, update the last-served pointer, and go to IDLE.
  - The non-granted master's ready stays 0.
- s_wstrb_o is forced to 0 in every state except ISSUE. s_addr_o and s_wdata_o may follow the grant mux in all states.
- Read data: m0_rdata_o and m1_rdata_o both pass s_rdata_i through combinationally. Only the ready pulse qualifies the data.
- Latency:
  - Valid seen in IDLE at cycle N gives ISSUE at N+1, s_ready_i at N+2, and mN_ready_o at N+2.
  - Back-to-back throughput is one transaction per 3 cycles.
- After the ready pulse, the master may drop valid or present a new request on the next cycle. That request is evaluated in IDLE, 1 cycle after ready.
- Arbitration ties (both valid in IDLE): resolved per the optional feature.
- Protocol violation:
  - If the granted master drops valid during ISSUE or WAIT, the transaction still completes and the ready pulse is still issued.
  - Write data and strobes were already sampled by the SRAM in ISSUE.
- Unexpected s_ready_i in IDLE or ISSUE is ignored and produces no ready pulse.
- Asynchronous reset mid-transaction: immediately return to IDLE, all outputs go to reset values, and no ready pulse is issued. Any write already strobed in ISSUE is not rolled back.
- No combinational path from mN_valid_i to mN_ready_o.

Optional Feature:
- Macro: SRAM_ARB_ROUND_ROBIN_EN.
- Defined:
  - On a tie, grant the master not served last; the last-served pointer is updated on each completion.
  - A single requester is granted regardless of the pointer.
- Not defined:
  - Fixed priority: master 0 always wins a tie, and the pointer logic is omitted.
  - Master 1 may starve under continuous master 0 traffic.

Test Plan:
- Single read: m0_valid_i=1, addr=0x0000_0010, wstrb=0, SRAM returns 0xDEADBEEF.
  -> s_select_o high for exactly one cycle at N+1; m0_ready_o pulses at N+2 with m0_rdata_o=0xDEADBEEF; m1_ready_o stays 0.
- Byte write: m1 writes wstrb=4'b0100, addr=0x0000_0008, wdata=0x00AB0000.
  -> s_wstrb_o=4'b0100 only during ISSUE, 0 at all other times; m1_ready_o pulses once; a later read returns byte 2 = 0xAB.
- Tie: both valid continuously for 4 transactions.
  -> SRAM_ARB_ROUND_ROBIN_EN defined: grants in order 0,1,0,1.
  -> Not defined: grants in order 0,0,0,0, and m1 never receives ready.
- Back-to-back: m0 re-asserts valid the cycle after its ready.
  -> Next s_select_o pulse occurs 3 cycles after the previous one; no lost or duplicated ready.
- Reset mid-WAIT: assert rst_i while in WAIT.
  -> All outputs go to 0 asynchronously; after release, a pending m1 request is issued cleanly from IDLE with exactly one ready pulse.
- Spurious s_ready_i=1 injected in IDLE.
  -> No mN_ready_o pulse and no state change.
